// File: rtl/gbuff_skew_feeder_pkg.sv
// Shared definitions for the global-buffer skew feeder and the array-side blocks
// that consume its skewed lanes.
package gbuff_skew_feeder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_READ  = 2'd1,
    FEED_DRAIN = 2'd2,
    FEED_FIN   = 2'd3
  } feed_state_e;

  localparam int LANE_SLICE_BITS = 8;

  // Cycles spent after the last read so the deepest lane can emit the last word.
  function automatic int drain_cycles(input int lanes);
    return (lanes > 1) ? lanes - 1 : 0;
  endfunction

endpackage

// File: rtl/gbuff_skew_feeder_skew_delay_line.sv
// Fixed-depth shift register carrying {valid,data}; DEPTH=0 is a plain wire.
module skew_delay_line #(
  parameter int DEPTH     = 1,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_shift
      logic [DATA_BITS:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= {in_valid, in_data};
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign {out_valid, out_data} = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/gbuff_skew_feeder.sv
// Streams LEN words out of the global buffer and presents them as a diagonal
// wavefront, lane r delayed by r cycles, for the systolic array row inputs.
module gbuff_skew_feeder
  import gbuff_skew_feeder_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = LANE_SLICE_BITS,
  parameter int LANES     = 4,
  parameter int LEN_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_BITS-1:0]         base_addr,
  input  logic [LEN_BITS-1:0]          length,
  output logic                         gb_wr_en,
  output logic [ADDR_BITS-1:0]         gb_index,
  input  logic [LANES*DATA_BITS-1:0]   gb_data,
  output logic [LANES*DATA_BITS-1:0]   lane_data,
  output logic [LANES-1:0]             lane_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int DRAIN_LEN  = drain_cycles(LANES);
  localparam int DRAIN_LAST = (DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0;
  localparam int DRAIN_W    = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  logic [1:0]                 state;
  logic [ADDR_BITS-1:0]       base_q;
  logic [LEN_BITS-1:0]        len_q;
  logic [LEN_BITS-1:0]        cnt;
  logic [DRAIN_W-1:0]         drain_cnt;
  logic                       cap_valid;
  logic [LANES*DATA_BITS-1:0] cap_data;

  assign gb_wr_en = 1'b0;

  // Control FSM. FIN spans two cycles: the first arms done, the second is the
  // visible done cycle, after which busy drops together with the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
      gb_index  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= length;
            cnt    <= '0;
            busy   <= 1'b1;
            if (length != '0) begin
              gb_index <= base_addr;
              state    <= ST_READ;
            end else begin
              state <= ST_FIN;
            end
          end
        end
        ST_READ: begin
          if (cnt == len_q - 1'b1) begin
            drain_cnt <= '0;
            state     <= (DRAIN_LEN == 0) ? ST_FIN : ST_DRAIN;
          end else begin
            cnt      <= cnt + 1'b1;
            gb_index <= base_q + ADDR_BITS'(cnt + 1'b1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_W'(DRAIN_LAST)) begin
            state <= ST_FIN;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // The buffer updates data_out on the falling edge, so the word addressed
  // during a READ cycle is stable by the next rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      cap_valid <= (state == ST_READ);
      cap_data  <= (state == ST_READ) ? gb_data : '0;
    end
  end

  generate
    for (genvar r = 0; r < LANES; r++) begin : g_lane
      skew_delay_line #(
        .DEPTH     (r),
        .DATA_BITS (DATA_BITS)
      ) u_skew (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (cap_valid),
        .in_data   (cap_data[r*DATA_BITS +: DATA_BITS]),
        .out_valid (lane_valid[r]),
        .out_data  (lane_data[r*DATA_BITS +: DATA_BITS])
      );
    end
  endgenerate

endmodule

// File: tb/tb_gbuff_skew_feeder.sv
// Directed bench for gbuff_skew_feeder with a negedge-registered buffer model.
module tb_gbuff_skew_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  length;
  logic        gb_wr_en;
  logic [7:0]  gb_index;
  logic [31:0] gb_data;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic        busy;
  logic        done;

  logic [31:0] mem [256];
  int total;
  int bad;

  gbuff_skew_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .gb_wr_en   (gb_wr_en),
    .gb_index   (gb_index),
    .gb_data    (gb_data),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: read port registered on the falling edge
  always @(negedge clk) begin
    if (!gb_wr_en) gb_data <= mem[gb_index];
  end

  task automatic test_reset();
    total++;
    if ({busy, done, lane_valid, lane_data, gb_index, gb_wr_en} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b valid=%b data=%h idx=%h wr=%b, need all 0",
               busy, done, lane_valid, lane_data, gb_index, gb_wr_en);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, lane_valid} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_release_idle: got busy=%b done=%b valid=%b, need 0", busy, done, lane_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w [3];
    logic [3:0]  ev;
    logic [31:0] ed;
    int k;
    w[0] = 32'h04030201; w[1] = 32'h08070605; w[2] = 32'h0C0B0A09;
    start = 1'b1; base_addr = 8'h10; length = 8'd3;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 8'h00; length = 8'd0;
    total++;
    if (busy !== 1'b1 || gb_index !== 8'h10 || lane_valid !== 4'b0) begin
      bad++;
      $display("[TB] FAIL basic_accept: got busy=%b idx=%h valid=%b, need 1 10 0000", busy, gb_index, lane_valid);
    end
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      ev = '0; ed = '0;
      for (int r = 0; r < 4; r++) begin
        k = n - 1 - r;
        if (k >= 0 && k < 3) begin
          ev[r] = 1'b1;
          ed[r*8 +: 8] = w[k][r*8 +: 8];
        end
      end
      total++;
      if (lane_valid !== ev || lane_data !== ed) begin
        bad++;
        $display("[TB] FAIL basic_lanes E%0d: got valid=%b data=%h, need valid=%b data=%h", n, lane_valid, lane_data, ev, ed);
      end
      total++;
      if (done !== (n == 7) || busy !== (n <= 7)) begin
        bad++;
        $display("[TB] FAIL basic_done_busy E%0d: got done=%b busy=%b, need done=%b busy=%b", n, done, busy, n == 7, n <= 7);
      end
      if (n < 3) begin
        total++;
        if (gb_index !== 8'h10 + 8'(n)) begin
          bad++;
          $display("[TB] FAIL basic_index E%0d: got %h, need %h", n, gb_index, 8'h10 + 8'(n));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_idx [3];
    logic [7:0] exp_l0 [3];
    logic [7:0] exp_l3 [3];
    exp_idx[0] = 8'hFE; exp_idx[1] = 8'hFF; exp_idx[2] = 8'h00;
    exp_l0[0] = 8'h10; exp_l0[1] = 8'h14; exp_l0[2] = 8'h18;
    exp_l3[0] = 8'h13; exp_l3[1] = 8'h17; exp_l3[2] = 8'h1B;
    start = 1'b1; base_addr = 8'hFE; length = 8'd3;
    for (int n = 0; n <= 8; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n <= 2) begin
        total++;
        if (gb_index !== exp_idx[n]) begin
          bad++;
          $display("[TB] FAIL wrap_index E%0d: got %h, need %h", n, gb_index, exp_idx[n]);
        end
      end
      if (n >= 1 && n <= 3) begin
        total++;
        if (lane_valid[0] !== 1'b1 || lane_data[7:0] !== exp_l0[n-1]) begin
          bad++;
          $display("[TB] FAIL wrap_lane0 E%0d: got v=%b d=%h, need v=1 d=%h", n, lane_valid[0], lane_data[7:0], exp_l0[n-1]);
        end
      end
      if (n >= 4 && n <= 6) begin
        total++;
        if (lane_valid[3] !== 1'b1 || lane_data[31:24] !== exp_l3[n-4]) begin
          bad++;
          $display("[TB] FAIL wrap_lane3 E%0d: got v=%b d=%h, need v=1 d=%h", n, lane_valid[3], lane_data[31:24], exp_l3[n-4]);
        end
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wrap_idle: got busy=%b, need 0", busy);
    end
  endtask

  task automatic test_zero_len();
    start = 1'b1; base_addr = 8'h20; length = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_accept: got busy=%b done=%b, need 1 0", busy, done);
    end
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      total++;
      if (lane_valid !== 4'b0 || done !== (n == 1) || busy !== (n <= 1)) begin
        bad++;
        $display("[TB] FAIL zero_len E%0d: got valid=%b done=%b busy=%b, need 0000 %b %b",
                 n, lane_valid, done, busy, n == 1, n <= 1);
      end
    end
  endtask

  task automatic test_start_busy();
    int dones;
    int idx40;
    dones = 0; idx40 = 0;
    start = 1'b1; base_addr = 8'h30; length = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 1) begin
        start = 1'b1; base_addr = 8'h40; length = 8'd5;
      end
      if (gb_index === 8'h40) idx40++;
      if (done === 1'b1) dones++;
      if (n == 3) begin
        total++;
        if (lane_data[7:0] !== 8'h39) begin
          bad++;
          $display("[TB] FAIL busy_lane0_last: got %h, need 39", lane_data[7:0]);
        end
      end
    end
    total++;
    if (idx40 !== 0 || dones !== 1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_start_ignored: got idx40=%0d dones=%0d busy=%b, need 0 1 0", idx40, dones, busy);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    start = 1'b1; base_addr = 8'h50; length = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, lane_valid, lane_data, gb_index, gb_wr_en} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got busy=%b done=%b valid=%b data=%h idx=%h, need all 0",
               busy, done, lane_valid, lane_data, gb_index);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if ({busy, done, lane_valid, gb_index} !== '0) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("[TB] FAIL midreset_no_resume: got %0d active cycles, need 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa [2];
    logic [31:0] wb [2];
    logic [3:0]  ev;
    logic [31:0] ed;
    int ka;
    int kb;
    wa[0] = 32'hA3A2A1A0; wa[1] = 32'hA7A6A5A4;
    wb[0] = 32'hB3B2B1B0; wb[1] = 32'hB7B6B5B4;
    start = 1'b1; base_addr = 8'h60; length = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ev = '0; ed = '0;
      for (int r = 0; r < 4; r++) begin
        ka = n - 1 - r;
        kb = n - 9 - r;
        if (ka >= 0 && ka < 2) begin
          ev[r] = 1'b1; ed[r*8 +: 8] = wa[ka][r*8 +: 8];
        end
        if (kb >= 0 && kb < 2) begin
          ev[r] = 1'b1; ed[r*8 +: 8] = wb[kb][r*8 +: 8];
        end
      end
      total++;
      if (lane_valid !== ev || lane_data !== ed) begin
        bad++;
        $display("[TB] FAIL b2b_lanes E%0d: got valid=%b data=%h, need valid=%b data=%h", n, lane_valid, lane_data, ev, ed);
      end
      total++;
      if (done !== (n == 6 || n == 14) || busy !== (n <= 6 || (n >= 8 && n <= 14))) begin
        bad++;
        $display("[TB] FAIL b2b_done_busy E%0d: got done=%b busy=%b", n, done, busy);
      end
      if (n == 7) begin
        start = 1'b1; base_addr = 8'h70; length = 8'd2;
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | i;
    mem[8'h10] = 32'h04030201; mem[8'h11] = 32'h08070605; mem[8'h12] = 32'h0C0B0A09;
    mem[8'hFE] = 32'h13121110; mem[8'hFF] = 32'h17161514; mem[8'h00] = 32'h1B1A1918;
    mem[8'h30] = 32'h31313131; mem[8'h31] = 32'h35353535; mem[8'h32] = 32'h39393939;
    mem[8'h40] = 32'h40404040;
    mem[8'h60] = 32'hA3A2A1A0; mem[8'h61] = 32'hA7A6A5A4;
    mem[8'h70] = 32'hB3B2B1B0; mem[8'h71] = 32'hB7B6B5B4;
    gb_data = '0;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    #2;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
